// File: rtl/rank_order_filter.sv
// rank_order_filter: pipelined odd-even transposition sort of a pixel window with runtime rank select and centre bypass.
module rank_order_filter #(
  parameter int PIX_DATA_W    = 12,
  parameter int WINDOW_SIZE   = 3,
  parameter int INPUTS_AMOUNT = WINDOW_SIZE**2,
  parameter int RANK_W        = $clog2(INPUTS_AMOUNT)
)(
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     data_valid_i,
  output logic                                     data_ready_o,
  input  logic [INPUTS_AMOUNT-1:0][PIX_DATA_W-1:0] data_i,
  input  logic [RANK_W-1:0]                        rank_i,
  input  logic                                     bypass_i,
  output logic                                     data_valid_o,
  input  logic                                     data_ready_i,
  output logic [PIX_DATA_W-1:0]                    data_o,
  output logic                                     rank_err_o
);
  localparam int N = INPUTS_AMOUNT;
  localparam logic [RANK_W-1:0] RMAX = RANK_W'(N - 1);
  typedef logic [N-1:0][PIX_DATA_W-1:0] win_t;
  function automatic win_t cx(input win_t a, input int k);
    win_t r;
    r = a;
    for (int j = k % 2; j < N - 1; j += 2)
      if (a[j] > a[j+1]) begin
        r[j]   = a[j+1];
        r[j+1] = a[j];
      end
    return r;
  endfunction
  win_t                  arr [N];
  logic [RANK_W-1:0]     rk  [N];
  logic                  byp [N];
  logic [PIX_DATA_W-1:0] ctr [N];
  logic [N-1:0]          v;
  logic                  stall, accept;
  logic [RANK_W-1:0]     rank_c;
  assign stall        = data_valid_o && !data_ready_i;
  assign data_ready_o = !stall;
  assign accept       = data_valid_i && data_ready_o;
  assign rank_c       = rank_i > RMAX ? RMAX : rank_i;
  // Payload travels without reset; only the valid chain decides what is real.
  always_ff @(posedge clk_i)
    if (!stall) begin
      arr[0] <= cx(data_i, 0);
      rk[0]  <= rank_c;
      byp[0] <= bypass_i;
      ctr[0] <= data_i[N/2];
      for (int i = 1; i < N; i++) begin
        arr[i] <= cx(arr[i-1], i);
        rk[i]  <= rk[i-1];
        byp[i] <= byp[i-1];
        ctr[i] <= ctr[i-1];
      end
    end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      v            <= '0;
      data_valid_o <= 1'b0;
      data_o       <= '0;
      rank_err_o   <= 1'b0;
    end else begin
      if (accept && rank_i > RMAX) rank_err_o <= 1'b1;
      if (!stall) begin
        v            <= {v[N-2:0], accept};
        data_valid_o <= v[N-1];
        if (v[N-1]) data_o <= byp[N-1] ? ctr[N-1] : arr[N-1][rk[N-1]];
      end
    end
endmodule

// File: tb/tb_rank_order_filter.sv
// tb_rank_order_filter: directed and random windows checked against a sort-based scoreboard.
module tb_rank_order_filter;
  logic             clk = 0;
  logic             rst_i = 0;
  logic             data_valid_i = 0;
  logic             data_ready_o;
  logic [8:0][11:0] data_i = '0;
  logic [3:0]       rank_i = '0;
  logic             bypass_i = 0;
  logic             data_valid_o;
  logic             data_ready_i = 1;
  logic [11:0]      data_o;
  logic             rank_err_o;
  int vectors = 0, miscompares = 0, n_out = 0;
  bit accepted, rnd_ready = 0, err_exp = 0;
  logic [11:0] exp_q[$];
  always #5 clk = ~clk;
  rank_order_filter dut (
    .clk_i(clk), .rst_i(rst_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
    .data_i(data_i), .rank_i(rank_i), .bypass_i(bypass_i), .data_valid_o(data_valid_o),
    .data_ready_i(data_ready_i), .data_o(data_o), .rank_err_o(rank_err_o));
  function automatic logic [11:0] model(input logic [8:0][11:0] w, input int r, input bit b);
    int q[$];
    if (b) return w[4];
    for (int i = 0; i < 9; i++) q.push_back(int'(w[i]));
    q.sort();
    return 12'(q[r > 8 ? 8 : r]);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    bit acc;
    if (rnd_ready) data_ready_i = ($urandom_range(0, 3) != 0);
    #1;
    chk("rank_err", rank_err_o, err_exp);
    chk("ready_rule", data_ready_o, !(data_valid_o && !data_ready_i));
    if (data_valid_o && data_ready_i) begin
      if (exp_q.size() == 0) chk("unexpected_out", data_valid_o, 0);
      else begin
        chk("out", data_o, exp_q.pop_front());
        n_out++;
      end
    end
    acc = data_valid_i && data_ready_o;
    if (acc) begin
      exp_q.push_back(model(data_i, rank_i, bypass_i));
      if (rank_i > 8) err_exp = 1;
    end
    accepted = acc;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [8:0][11:0] w, input int r, input bit b);
    int n = 0;
    data_i = w;
    rank_i = 4'(r);
    bypass_i = b;
    data_valid_i = 1;
    do begin
      tick();
      n++;
    end while (!accepted && n < 100);
    if (!accepted) chk("accept_timeout", 0, 1);
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    while (!data_valid_o && n < 50) begin
      tick();
      n++;
    end
    chk("wait_valid", data_valid_o, 1);
  endtask
  task automatic drain(input int n);
    data_valid_i = 0;
    repeat (n) tick();
  endtask
  function automatic logic [8:0][11:0] rnd_win(input int pat);
    logic [8:0][11:0] w;
    logic [11:0] e;
    e = 12'($urandom);
    for (int i = 0; i < 9; i++)
      w[i] = pat == 0 ? e : pat == 1 ? ($urandom_range(0, 1) ? 12'hFFF : 12'h000) : 12'($urandom);
    return w;
  endfunction
  initial begin
    logic [8:0][11:0] w, desc, ramp, ctrw;
    logic [11:0] hold;
    int n, base;
    for (int i = 0; i < 9; i++) begin
      desc[i] = 12'(9 - i);
      ramp[i] = 12'(i);
      ctrw[i] = 12'h000;
    end
    ctrw[4] = 12'hABC;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", data_valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_err", rank_err_o, 0);
    chk("rst_ready", data_ready_o, 1);
    rst_i = 1;
    tick();
    send(desc, 4, 0);
    data_valid_i = 0;
    wait_valid(n);
    chk("latency", n, 9);
    chk("median", data_o, 5);
    drain(3);
    send(desc, 0, 0);
    send(desc, 8, 0);
    send(desc, 4, 0);
    data_valid_i = 0;
    wait_valid(n);
    chk("b2b_min", data_o, 1);
    tick();
    chk("b2b_max_valid", data_valid_o, 1);
    chk("b2b_max", data_o, 9);
    tick();
    chk("b2b_med_valid", data_valid_o, 1);
    chk("b2b_med", data_o, 5);
    drain(3);
    send(ctrw, 0, 1);
    send(ctrw, 4, 0);
    data_valid_i = 0;
    wait_valid(n);
    chk("bypass", data_o, 12'hABC);
    tick();
    chk("no_bypass", data_o, 0);
    drain(3);
    base = n_out;
    for (int i = 0; i < 20; i++) begin
      w = rnd_win(2);
      if (i == 12) begin
        data_i = w;
        data_valid_i = 1;
        data_ready_i = 0;
        #1;
        hold = data_o;
        repeat (3) begin
          chk("stall_ready", data_ready_o, 0);
          chk("stall_valid", data_valid_o, 1);
          chk("stall_hold", data_o, hold);
          tick();
        end
        data_ready_i = 1;
      end
      send(w, $urandom_range(0, 8), 0);
    end
    drain(15);
    chk("stream_count", n_out - base, 20);
    chk("stream_empty", exp_q.size(), 0);
    chk("err_before", rank_err_o, 0);
    send(ramp, 12, 0);
    data_valid_i = 0;
    chk("rank_err_set", rank_err_o, 1);
    wait_valid(n);
    chk("clamped", data_o, 8);
    drain(3);
    rnd_ready = 1;
    for (int i = 0; i < 40; i++) send(rnd_win(i % 3), $urandom_range(0, 8), $urandom_range(0, 5) == 0);
    rnd_ready = 0;
    data_ready_i = 1;
    drain(20);
    chk("rand_empty", exp_q.size(), 0);
    chk("err_sticky", rank_err_o, 1);
    for (int i = 0; i < 5; i++) send(rnd_win(2), i, 0);
    data_valid_i = 0;
    rst_i = 0;
    #1;
    chk("async_valid", data_valid_o, 0);
    chk("async_err", rank_err_o, 0);
    exp_q.delete();
    err_exp = 0;
    @(posedge clk);
    #1;
    rst_i = 1;
    drain(12);
    send(desc, 2, 0);
    data_valid_i = 0;
    wait_valid(n);
    chk("post_rst_latency", n, 9);
    chk("post_rst_data", data_o, 3);
    drain(5);
    chk("final_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
